fp_sub: RTL and testbench
=========================

FP_SUB -- requirements
Module: fp_sub

Interface
REQ-001 Parameter N SHALL default to 32 (IEEE-754 single); exponent width N/4, fraction width N-N/4-1; only N=32 is supported.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 in_valid  input  1  A/B operand pair valid.
REQ-005 in_ready  output  1  block accepts operands this cycle.
REQ-006 A  input  N  minuend, packed sign/exponent/fraction.
REQ-007 B  input  N  subtrahend, same format.
REQ-008 out_valid  output  1  Diff valid.
REQ-009 out_ready  input  1  consumer accepts Diff.
REQ-010 Diff  output  N  packed result A-B.
REQ-011 flags  output  3  {invalid, overflow, underflow}, qualified by out_valid.

Function
REQ-012 Operation SHALL be Diff = A - B, implemented as A + (B with sign inverted), covering both effective add and effective subtract.
REQ-013 Three-stage pipeline: S1 unpack/swap/align, S2 add-or-subtract magnitudes, S3 leading-zero normalize/round/pack; latency exactly 3 cycles with no stall.
REQ-014 Transfer in on in_valid&&in_ready; transfer out on out_valid&&out_ready.
REQ-015 in_ready SHALL equal (!out_valid || out_ready); when low, every stage holds its contents; no bubble collapse required.
REQ-016 Throughput: one result per cycle while out_ready is held high.
REQ-017 S1: larger-magnitude operand to Op1 (compare exponent, then fraction); result sign = sign of Op1 after B inversion; Op2 right-shifted by the exponent difference into a 24+3-bit significand (guard, round, sticky); shifts >=27 leave sticky only.
REQ-018 S2: 28-bit magnitude add when effective signs match, otherwise subtract (Op1-Op2, never negative).
REQ-019 S3: carry-out -> shift right 1 and exponent +1; otherwise shift left by leading-zero count, exponent decremented accordingly; round to nearest, ties to even.
REQ-020 Exact cancellation (zero magnitude) SHALL give +0 (0x00000000).
REQ-021 Result exponent >= 255 after rounding -> signed infinity, overflow=1.
REQ-022 Result exponent <= 0 -> signed zero, underflow=1 (flush to zero); denormal inputs are treated as zero.
REQ-023 Any NaN input, or inf - inf with equal signs, -> 0x7FC00000, invalid=1; inf minus finite -> that inf; finite minus inf -> opposite-signed inf.
REQ-024 A == B (including both zero with equal sign) -> +0; (+0)-(+0)=+0, (-0)-(+0)=-0.

Reset
REQ-025 While rst_n low at a clock edge: all stage valid bits, out_valid, Diff, flags cleared to 0; in_ready reads 1 in the cycle after reset releases.
REQ-026 Reset mid-operation SHALL discard all in-flight operands; no result for them is ever presented.
REQ-027 Datapath registers other than valid bits MAY be left unreset but SHALL never drive Diff while out_valid is 0 (Diff held 0).

Structure
REQ-028 Package fp_pkg SHALL hold EXP_W, FRAC_W, BIAS (127), EXP_MAX (255), QNAN (0x7FC00000), and the unpacked-operand struct {sign, exp, significand}.
REQ-029 One sub-module, fp_lzc: combinational 28-bit leading-zero counter used in S3.
REQ-030 Stage enables SHALL derive from the single in_ready term; no per-stage handshakes.

Verification
REQ-031 A=0x40400000 (3.0), B=0x3F800000 (1.0), out_ready=1 -> Diff=0x40000000 after 3 cycles, flags=0.
REQ-032 A=0x3F800000, B=0xBF800000 (1.0 - -1.0) -> 0x40000000; A=B=0x3F800000 -> 0x00000000.
REQ-033 A=0x3F800000, B=0x3F7FFFFF -> 0x33800000 (massive cancellation, 23-bit normalize).
REQ-034 A=0x7F7FFFFF, B=0xFF7FFFFF -> 0x7F800000, overflow=1; A=B=0x7F800000 -> 0x7FC00000, invalid=1.
REQ-035 Stream 8 random pairs, out_ready low for cycles 4-6 -> in_ready low those cycles, no result lost or duplicated, order preserved vs. reference model.
REQ-036 rst_n low one cycle with 3 results in flight -> out_valid 0 next cycle; no stale Diff emitted afterwards.

Source files
------------

// File: rtl/fp_pkg.sv
// Shared widths, constants and operand layout for the single-precision subtractor.
package fp_pkg;

    localparam int unsigned EXP_W   = 8;
    localparam int unsigned FRAC_W  = 23;
    localparam int unsigned SIG_W   = FRAC_W + 1;
    localparam int unsigned ALN_W   = SIG_W + 3;
    localparam int unsigned MAG_W   = ALN_W + 1;
    localparam int unsigned LZ_W    = 5;
    localparam int unsigned BIAS    = 127;
    localparam int unsigned EXP_MAX = 255;
    localparam logic [31:0] QNAN    = 32'h7FC0_0000;

    typedef struct packed {
        logic             sign;
        logic [EXP_W-1:0] exp;
        logic [SIG_W-1:0] sig;
    } fp_unp_t;

    // Denormals collapse to zero significand; hidden bit restored otherwise.
    function automatic fp_unp_t fp_unpack(input logic [31:0] x);
        fp_unp_t u;
        u.sign = x[31];
        u.exp  = x[30:23];
        u.sig  = (x[30:23] == 8'd0) ? 24'd0 : {1'b1, x[22:0]};
        return u;
    endfunction

endpackage

// File: rtl/fp_lzc.sv
// Combinational leading-zero counter over the 28-bit magnitude.
module fp_lzc
    import fp_pkg::*;
(
    input  logic [MAG_W-1:0] x,
    output logic [LZ_W-1:0]  lz_c
);

    logic found;

    always_comb begin
        lz_c  = LZ_W'(MAG_W);
        found = 1'b0;
        for (int i = int'(MAG_W) - 1; i >= 0; i--) begin
            if (!found && x[i]) begin
                lz_c  = LZ_W'(int'(MAG_W) - 1 - i);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fp_sub.sv
// Three-stage pipelined IEEE-754 single subtractor: align, add/sub, normalize/round/pack.
module fp_sub
    import fp_pkg::*;
#(
    parameter int unsigned N = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] Diff,
    output logic [2:0]   flags
);

    localparam logic signed [9:0] EMAX_S = 10'(EXP_MAX);

    logic en;
    assign in_ready = !out_valid || out_ready;
    assign en       = in_ready;

    // S1: unpack, swap by magnitude, align smaller operand
    fp_unp_t          ua, ub, op1;
    logic [EXP_W-1:0] op2_exp, ediff;
    logic [SIG_W-1:0] op2_sig;
    logic [4:0]       shamt;
    logic [49:0]      wide;
    logic [ALN_W-1:0] aligned2;
    logic             nan_a, nan_b, inf_a, inf_b, a_ge, spec;
    logic [31:0]      spec_val;
    logic [2:0]       spec_flg;

    always_comb begin
        ua       = fp_unpack(A);
        ub       = fp_unpack(B);
        ub.sign  = ~B[N-1];
        nan_a    = (&A[30:23]) && (|A[22:0]);
        nan_b    = (&B[30:23]) && (|B[22:0]);
        inf_a    = (&A[30:23]) && !(|A[22:0]);
        inf_b    = (&B[30:23]) && !(|B[22:0]);
        a_ge     = {ua.exp, ua.sig} >= {ub.exp, ub.sig};
        op1      = a_ge ? ua : ub;
        op2_exp  = a_ge ? ub.exp : ua.exp;
        op2_sig  = a_ge ? ub.sig : ua.sig;
        ediff    = op1.exp - op2_exp;
        shamt    = (ediff > 8'd27) ? 5'd27 : ediff[4:0];
        wide     = {op2_sig, 26'd0} >> shamt;
        aligned2 = {wide[49:24], |wide[23:0]};

        spec     = nan_a || nan_b || inf_a || inf_b;
        spec_val = '0;
        spec_flg = '0;
        if (nan_a || nan_b || (inf_a && inf_b && (ua.sign != ub.sign))) begin
            spec_val = QNAN;
            spec_flg = 3'b100;
        end else if (inf_a) begin
            spec_val = {ua.sign, 8'hFF, 23'd0};
        end else begin
            spec_val = {ub.sign, 8'hFF, 23'd0};
        end
    end

    logic             s1_v, s1_sign, s1_sub, s1_spec;
    logic [EXP_W-1:0] s1_exp;
    logic [ALN_W-1:0] s1_m1, s1_m2;
    logic [31:0]      s1_sval;
    logic [2:0]       s1_sflg;

    // S2: magnitude add or subtract (op1 >= op2, never negative)
    logic [MAG_W-1:0] mag;
    assign mag = s1_sub ? ({1'b0, s1_m1} - {1'b0, s1_m2})
                        : ({1'b0, s1_m1} + {1'b0, s1_m2});

    logic             s2_v, s2_sign, s2_sub, s2_spec;
    logic [EXP_W-1:0] s2_exp;
    logic [MAG_W-1:0] s2_mag;
    logic [31:0]      s2_sval;
    logic [2:0]       s2_sflg;

    // S3: normalize, round to nearest even, pack with range checks
    logic [LZ_W-1:0]   lz;
    logic [ALN_W-1:0]  norm;
    logic signed [9:0] exp_n, exp_r;
    logic [24:0]       man;
    logic              up;
    logic [22:0]       frac;
    logic [31:0]       res;
    logic [2:0]        flg;

    fp_lzc u_lzc (
        .x    (s2_mag),
        .lz_c (lz)
    );

    always_comb begin
        norm  = '0;
        exp_n = '0;
        exp_r = '0;
        man   = '0;
        up    = 1'b0;
        frac  = '0;
        res   = '0;
        flg   = '0;
        if (s2_spec) begin
            res = s2_sval;
            flg = s2_sflg;
        end else if (s2_mag == '0) begin
            res = {s2_sign & ~s2_sub, 31'd0};
        end else begin
            if (s2_mag[MAG_W-1]) begin
                norm  = {s2_mag[27:2], s2_mag[1] | s2_mag[0]};
                exp_n = signed'({2'b00, s2_exp}) + 10'sd1;
            end else begin
                norm  = ALN_W'(s2_mag << (lz - 5'd1));
                exp_n = signed'({2'b00, s2_exp}) - signed'({5'd0, lz}) + 10'sd1;
            end
            up    = norm[2] & (norm[1] | norm[0] | norm[3]);
            man   = {1'b0, norm[26:3]} + 25'(up);
            exp_r = exp_n + signed'({9'd0, man[24]});
            frac  = man[24] ? man[23:1] : man[22:0];
            if (exp_r >= EMAX_S) begin
                res = {s2_sign, 8'hFF, 23'd0};
                flg = 3'b010;
            end else if (exp_r <= 10'sd0) begin
                res = {s2_sign, 31'd0};
                flg = 3'b001;
            end else begin
                res = {s2_sign, exp_r[7:0], frac};
            end
        end
    end

    // Valid chain and output registers; all advance together on the single enable
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_v      <= 1'b0;
            s2_v      <= 1'b0;
            out_valid <= 1'b0;
            Diff      <= '0;
            flags     <= '0;
        end else if (en) begin
            s1_v      <= in_valid;
            s2_v      <= s1_v;
            out_valid <= s2_v;
            Diff      <= s2_v ? N'(res) : '0;
            flags     <= s2_v ? flg : 3'b000;
        end
    end

    always_ff @(posedge clk) begin
        if (en) begin
            s1_sign <= op1.sign;
            s1_sub  <= ua.sign ^ ub.sign;
            s1_exp  <= op1.exp;
            s1_m1   <= {op1.sig, 3'b000};
            s1_m2   <= aligned2;
            s1_spec <= spec;
            s1_sval <= spec_val;
            s1_sflg <= spec_flg;
            s2_sign <= s1_sign;
            s2_sub  <= s1_sub;
            s2_exp  <= s1_exp;
            s2_mag  <= mag;
            s2_spec <= s1_spec;
            s2_sval <= s1_sval;
            s2_sflg <= s1_sflg;
        end
    end

endmodule

// File: tb/tb_fp_sub.sv
// Scoreboard bench for fp_sub against an exact-integer reference of A - B.
module tb_fp_sub;
    import fp_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n, in_valid, in_ready, out_valid, out_ready;
    logic [31:0] A, B, Diff;
    logic [2:0]  flags;

    always #5 clk = ~clk;

    fp_sub #(.N(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Diff      (Diff),
        .flags     (flags)
    );

    int checks = 0, errors = 0;
    int issued = 0, received = 0, discarded = 0;
    int stream_cyc = 0;
    bit stall_en = 0, rnd_or = 0;
    logic [34:0] sb_q[$];
    logic [34:0] mon_exp;
    logic [31:0] spec_tab[6] = '{32'h0000_0000, 32'h8000_0000, 32'h7F80_0000,
                                 32'hFF80_0000, 32'h7FC0_0001, 32'h0000_0005};

    function automatic void chk(input string name, input logic [34:0] act, input logic [34:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %h required %h", name, act, exp);
        end
    endfunction

    // Exact value = sig * 2^(e-1) in units of 2^-149, rounded once to 24 bits.
    function automatic logic [34:0] ref_sub(input logic [31:0] a, input logic [31:0] b);
        logic sa, sb, rs;
        int ea, eb, p, sh, e;
        logic [279:0] ma, mb, diff, q, rem, half;
        sa = a[31];
        sb = ~b[31];
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
        if ((ea == 255 && a[22:0] != 0) || (eb == 255 && b[22:0] != 0)) return {3'b100, QNAN};
        if (ea == 255 && eb == 255) return (sa != sb) ? {3'b100, QNAN} : {3'b000, a};
        if (ea == 255) return {3'b000, a};
        if (eb == 255) return {3'b000, sb, 8'hFF, 23'd0};
        ma = (ea == 0) ? 280'd0 : (280'({1'b1, a[22:0]}) << (ea - 1));
        mb = (eb == 0) ? 280'd0 : (280'({1'b1, b[22:0]}) << (eb - 1));
        if (ma == 0 && mb == 0) return {3'b000, sa & sb, 31'd0};
        if (sa == sb) begin
            diff = ma + mb; rs = sa;
        end else if (ma > mb) begin
            diff = ma - mb; rs = sa;
        end else if (mb > ma) begin
            diff = mb - ma; rs = sb;
        end else begin
            return 35'd0;
        end
        p = 0;
        for (int i = 279; i >= 0; i--) begin
            if (diff[i]) begin
                p = i;
                break;
            end
        end
        e = p - 22;
        if (e <= 0) return {3'b001, rs, 31'd0};
        sh  = p - 23;
        q   = diff >> sh;
        rem = diff - (q << sh);
        if (sh > 0) begin
            half = 280'd1 << (sh - 1);
            if (rem > half || (rem == half && q[0])) q = q + 280'd1;
        end
        if (q[24]) begin
            q = q >> 1;
            e++;
        end
        if (e >= 255) return {3'b010, rs, 8'hFF, 23'd0};
        return {3'b000, rs, 8'(e), q[22:0]};
    endfunction

    function automatic logic [31:0] rnd_fp(input int lo, input int hi);
        return {1'($urandom_range(0, 1)), 8'($urandom_range(hi, lo)), 23'($urandom)};
    endfunction

    task automatic gen_pair(output logic [31:0] a, output logic [31:0] b);
        int m, ea, lo;
        m  = $urandom_range(0, 9);
        a  = rnd_fp(int'(BIAS) - 20, int'(BIAS) + 20);
        ea = int'(a[30:23]);
        lo = (ea - 30 < 1) ? 1 : ea - 30;
        case (m)
            0: b = spec_tab[$urandom_range(0, 5)];
            1: b = a ^ {1'($urandom_range(0, 1)), 31'd0};
            2: b = {1'($urandom_range(0, 1)), a[30:0] + 31'($urandom_range(1, 3))};
            3: begin a = rnd_fp(252, 254); b = rnd_fp(252, 254); end
            4: begin a = rnd_fp(1, 4); b = rnd_fp(1, 4); end
            5: b = $urandom;
            6: begin a = spec_tab[$urandom_range(0, 5)]; b = rnd_fp(lo, ea + 30); end
            default: b = rnd_fp(lo, ea + 30);
        endcase
    endtask

    // Hold the operand pair until the DUT accepts it; expected result enqueued on acceptance.
    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [34:0] exp);
        bit done = 0;
        bit stall;
        for (int t = 0; t < 200 && !done; t++) begin
            @(negedge clk);
            stall     = stall_en && stream_cyc >= 4 && stream_cyc <= 6;
            out_ready = rnd_or ? ($urandom_range(0, 3) != 0) : !stall;
            in_valid  = 1'b1;
            A         = a;
            B         = b;
            #1;
            if (stall) chk("stall_in_ready", 35'(in_ready), 35'd0);
            if (in_ready) begin
                sb_q.push_back(exp);
                issued++;
                done = 1;
            end
            stream_cyc++;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL issue_timeout: actual not_accepted required accepted");
        end
    endtask

    task automatic issue_rand();
        logic [31:0] a, b;
        gen_pair(a, b);
        issue(a, b, ref_sub(a, b));
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            in_valid  = 1'b0;
            out_ready = 1'b1;
        end
    endtask

    // Monitor: pop and compare on every output transfer; Diff must read zero when not valid.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (out_valid === 1'b1 && out_ready === 1'b1) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output: actual %h required none", {flags, Diff});
                end else begin
                    mon_exp = sb_q.pop_front();
                    chk("result", {flags, Diff}, mon_exp);
                    received++;
                end
            end else if (out_valid === 1'b0) begin
                chk("idle_zero", {flags, Diff}, 35'd0);
            end
        end
    end

    initial begin
        int lat;
        int rx_before;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; A = '0; B = '0;
        repeat (2) @(negedge clk);
        #1;
        chk("reset_out_valid", 35'(out_valid), 35'd0);
        chk("reset_diff", {flags, Diff}, 35'd0);
        chk("reset_in_ready", 35'(in_ready), 35'd1);
        rst_n = 1'b1;
        idle(2);

        // 3.0 - 1.0, with latency measured from the issue cycle
        issue(32'h4040_0000, 32'h3F80_0000, {3'b000, 32'h4000_0000});
        lat = 0;
        while (lat < 10) begin
            @(negedge clk);
            in_valid  = 1'b0;
            out_ready = 1'b1;
            lat++;
            #1;
            if (out_valid) break;
        end
        chk("latency", 35'(lat), 35'd3);
        idle(3);

        issue(32'h3F80_0000, 32'hBF80_0000, {3'b000, 32'h4000_0000});
        issue(32'h3F80_0000, 32'h3F80_0000, {3'b000, 32'h0000_0000});
        issue(32'h3F80_0000, 32'h3F7F_FFFF, {3'b000, 32'h3380_0000});
        issue(32'h7F7F_FFFF, 32'hFF7F_FFFF, {3'b010, 32'h7F80_0000});
        issue(32'h7F80_0000, 32'h7F80_0000, {3'b100, 32'h7FC0_0000});
        issue(32'h0000_0000, 32'h0000_0000, {3'b000, 32'h0000_0000});
        issue(32'h8000_0000, 32'h0000_0000, {3'b000, 32'h8000_0000});
        issue(32'h7FC0_0001, 32'h3F80_0000, {3'b100, 32'h7FC0_0000});
        issue(32'hFF80_0000, 32'h3F80_0000, {3'b000, 32'hFF80_0000});
        issue(32'h3F80_0000, 32'h7F80_0000, {3'b000, 32'hFF80_0000});
        issue(32'h7F80_0000, 32'hFF80_0000, {3'b000, 32'h7F80_0000});
        issue(32'h0080_0000, 32'h0080_0001, {3'b001, 32'h8000_0000});
        idle(5);

        // 8-pair stream with out_ready dropped for stream cycles 4-6
        stall_en = 1; stream_cyc = 0;
        repeat (8) issue_rand();
        stall_en = 0;
        idle(6);

        // Longer randomized run with random backpressure and input gaps
        rnd_or = 1;
        repeat (300) begin
            issue_rand();
            if ($urandom_range(0, 7) == 0) idle(1);
        end
        rnd_or = 0;
        idle(6);

        // Reset with three operands in flight
        repeat (3) issue_rand();
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        rst_n     = 1'b0;
        discarded += sb_q.size();
        sb_q.delete();
        rx_before = received;
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        #1;
        chk("post_reset_out_valid", 35'(out_valid), 35'd0);
        chk("post_reset_in_ready", 35'(in_ready), 35'd1);
        idle(6);
        chk("no_stale", 35'(received - rx_before), 35'd0);

        repeat (4) issue_rand();
        for (int t = 0; t < 100 && sb_q.size() != 0; t++) idle(1);
        idle(2);
        chk("drain", 35'(sb_q.size()), 35'd0);
        chk("count", 35'(received), 35'(issued - discarded));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
